// File: rtl/twos_to_bcd.sv
// rtl/twos_to_bcd.sv - sequential two's-complement to sign-magnitude BCD converter
//
// Purpose: captures a signed WIDTH-bit operand, negates it to a magnitude and
// runs WIDTH shift-and-add-3 iterations to produce DIGITS BCD digits.
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   asynchronous active-high reset
//   START  in   conversion request, honoured only in IDLE
//   IN     in   [WIDTH-1:0] two's-complement operand, captured on the accepting edge
//   BUSY   out  high while iterating
//   DONE   out  one-cycle pulse when SIGN/BCD carry a new result
//   SIGN   out  1 = negative result
//   BCD    out  [4*DIGITS-1:0] magnitude, digit 0 in bits [3:0]
module twos_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [WIDTH-1:0]      IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  SIGN,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_FINISH
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mag_q;
    logic [SW-1:0]    scratch_q;
    logic             sign_int_q;
    logic             busy_q;
    logic             done_q;
    logic             sign_q;
    logic [SW-1:0]    bcd_q;

    logic [SW-1:0]    scratch_adj;
    logic [SW-1:0]    scratch_d;
    logic [WIDTH-1:0] mag_d;
    logic [WIDTH-1:0] mag_in;

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        // The top bit of the adjusted scratch falls off; the parameter
        // constraint guarantees it is always zero.
        scratch_d = {scratch_adj[SW-2:0], mag_q[WIDTH-1]};
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        // Negating the most negative value wraps back to itself, which read as
        // unsigned is exactly 2^(WIDTH-1), the correct magnitude.
        mag_in    = IN[WIDTH-1] ? (~IN + WIDTH'(1)) : IN;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            sign_int_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sign_q     <= 1'b0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        sign_int_q <= IN[WIDTH-1];
                        mag_q      <= mag_in;
                        scratch_q  <= '0;
                        count_q    <= CW'(WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    scratch_q <= scratch_d;
                    mag_q     <= mag_d;
                    count_q   <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        // Last iteration: publish the result in the same edge.
                        bcd_q   <= scratch_d;
                        sign_q  <= sign_int_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SIGN = sign_q;
    assign BCD  = bcd_q;

endmodule

// File: tb/tb_twos_to_bcd.sv
// tb/tb_twos_to_bcd.sv - scoreboard bench for twos_to_bcd
module tb_twos_to_bcd;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  IN;
    logic        BUSY;
    logic        DONE;
    logic        SIGN;
    logic [11:0] BCD;

    int tests = 0;
    int fails = 0;

    logic [12:0] exp_q[$];
    logic        last_sign = 1'b0;
    logic [11:0] last_bcd  = 12'h000;

    twos_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .IN    (IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SIGN  (SIGN),
        .BCD   (BCD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (BUSY && DONE) chk("busy_and_done", 32'd1, 32'd0);
            if (DONE) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    chk("result_sign", {31'd0, SIGN}, {31'd0, e[12]});
                    chk("result_bcd", {20'd0, BCD}, {20'd0, e[11:0]});
                end
            end
        end
    end

    // One conversion: checks BUSY length, that outputs hold the previous
    // result while busy, and that DONE arrives right after BUSY drops.
    task automatic run_conv(input logic [7:0] v, input logic es, input logic [11:0] eb);
        int busy_cycles;
        @(negedge CLK);
        IN = v;
        START = 1'b1;
        exp_q.push_back({es, eb});
        @(negedge CLK);
        START = 1'b0;
        IN = ~v;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!BUSY) break;
            busy_cycles++;
            chk("hold_sign", {31'd0, SIGN}, {31'd0, last_sign});
            chk("hold_bcd", {20'd0, BCD}, {20'd0, last_bcd});
            @(negedge CLK);
        end
        chk("busy_cycles", busy_cycles, 32'd8);
        chk("done_after_busy", {31'd0, DONE}, 32'd1);
        last_sign = es;
        last_bcd  = eb;
        @(negedge CLK);
        chk("done_one_cycle", {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic b_hist[12];
        logic d_hist[12];
        RESET = 1'b1;
        START = 1'b0;
        IN    = 8'h00;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // 1: reset state and quiet idle
        repeat (4) @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_sign", {31'd0, SIGN}, 32'd0);
        chk("rst_bcd", {20'd0, BCD}, 32'd0);

        // 2 and 3: directed values
        run_conv(8'h05, 1'b0, 12'h005);
        run_conv(8'h7F, 1'b0, 12'h127);
        run_conv(8'hFB, 1'b1, 12'h005);
        run_conv(8'h80, 1'b1, 12'h128);
        run_conv(8'h00, 1'b0, 12'h000);

        // 4: START held high, IN changed while busy
        @(negedge CLK);
        IN = 8'h9C;
        START = 1'b1;
        exp_q.push_back({1'b1, 12'h100});
        exp_q.push_back({1'b0, 12'h001});
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (i == 0) IN = 8'h01;
            b_hist[i] = BUSY;
            d_hist[i] = DONE;
            if (i == 10) START = 1'b0;
        end
        chk("held_busy_k", {31'd0, b_hist[0]}, 32'd1);
        chk("held_busy_k7", {31'd0, b_hist[7]}, 32'd1);
        chk("held_done_k8", {31'd0, d_hist[8]}, 32'd1);
        chk("held_idle_k9_busy", {31'd0, b_hist[9]}, 32'd0);
        chk("held_idle_k9_done", {31'd0, d_hist[9]}, 32'd0);
        chk("held_accept_k10", {31'd0, b_hist[10]}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (DONE) break;
            @(negedge CLK);
        end
        chk("held_second_done", {31'd0, DONE}, 32'd1);
        last_sign = 1'b0;
        last_bcd  = 12'h001;
        @(negedge CLK);

        // 6: back-to-back, outputs hold the first result through the second run
        run_conv(8'h64, 1'b0, 12'h100);
        run_conv(8'hFF, 1'b1, 12'h001);

        // 5: asynchronous reset mid-conversion aborts without DONE
        @(negedge CLK);
        IN = 8'hC8;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_sign", {31'd0, SIGN}, 32'd0);
        chk("abort_bcd", {20'd0, BCD}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        last_sign = 1'b0;
        last_bcd  = 12'h000;
        repeat (12) @(negedge CLK);
        chk("abort_no_done", {31'd0, DONE}, 32'd0);
        run_conv(8'h2A, 1'b0, 12'h042);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
